// File: rtl/uart_stream_rx.sv
// uart_stream_rx: 8N1 UART receiver that gathers bytes into an 8-entry frame
// buffer with a registered read port. Flags frame completion, stop-bit
// framing errors and inter-byte idle timeouts.
// Optional reference-pattern compare is built only when the macro
// UART_STREAM_RX_CHECK_EN is defined; otherwise Match_o is tied low.
//
// Handshake note: there is no valid/ready flow control on this block. Done_o,
// FrameError_o and Timeout_o are single-cycle, mutually exclusive event pulses;
// the consumer samples them every cycle and reads the buffer at leisure.
module uart_stream_rx #(
    parameter int CLOCK_HZ     = 25_000_000,
    parameter int BAUD         = 115200,
    parameter int TIMEOUT_BITS = 20
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       Rx_i,
    input  logic [2:0] ReadAddr_i,
    output logic [7:0] ReadData_o,
    output logic [3:0] Count_o,
    output logic       Busy_o,
    output logic       Done_o,
    output logic       FrameError_o,
    output logic       Timeout_o,
    output logic       Match_o
);

    localparam int CYCLES_PER_BIT = CLOCK_HZ / BAUD;
    localparam int HALF_BIT       = CYCLES_PER_BIT / 2;
    localparam int TIMEOUT_CYCLES = TIMEOUT_BITS * CYCLES_PER_BIT;
    localparam int CNT_W          = $clog2(CYCLES_PER_BIT + 1);
    localparam int IDLE_W         = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [CNT_W-1:0]  HALF_LAST = CNT_W'(HALF_BIT - 1);
    localparam logic [CNT_W-1:0]  BIT_LAST  = CNT_W'(CYCLES_PER_BIT - 1);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_RECOVER
    } state_t;

    logic              rx_meta_q;
    logic              rx_sync_q;
    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [2:0]        bit_idx_q, bit_idx_d;
    logic [7:0]        shift_q, shift_d;
    logic [2:0]        ptr_q, ptr_d;
    logic [IDLE_W-1:0] idle_cnt_q, idle_cnt_d;
    logic [7:0]        buf_q [8];
    logic [7:0]        buf_d [8];
    logic [7:0]        rdata_q;
    logic              done_q, done_d;
    logic              ferr_q, ferr_d;
    logic              tout_q, tout_d;
    logic              stop_sample;

    // Stop-bit sampling instant; a high line here means the byte is stored.
    assign stop_sample = (state_q == S_STOP) && (cnt_q == BIT_LAST);

    // Two-flop synchroniser for the asynchronous RX pin, idling high.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
        end else begin
            rx_meta_q <= Rx_i;
            rx_sync_q <= rx_meta_q;
        end
    end

    // Bit FSM, frame pointer and idle-timeout next-state logic.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q + 1'b1;
        bit_idx_d  = bit_idx_q;
        shift_d    = shift_q;
        ptr_d      = ptr_q;
        idle_cnt_d = '0;
        buf_d      = buf_q;
        done_d     = 1'b0;
        ferr_d     = 1'b0;
        tout_d     = 1'b0;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (!rx_sync_q) begin
                    state_d = S_START;
                end else if (ptr_q != 3'd0) begin
                    // Partial frame waiting for its next byte.
                    if (idle_cnt_q == IDLE_LAST) begin
                        tout_d = 1'b1;
                        ptr_d  = 3'd0;
                    end else begin
                        idle_cnt_d = idle_cnt_q + 1'b1;
                    end
                end
            end
            S_START: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d = '0;
                    if (rx_sync_q) begin
                        state_d = S_IDLE;   // glitch, not a start bit
                    end else begin
                        state_d   = S_DATA;
                        bit_idx_d = 3'd0;
                    end
                end
            end
            S_DATA: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = '0;
                    shift_d = {rx_sync_q, shift_q[7:1]};
                    if (bit_idx_q == 3'd7) begin
                        state_d = S_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 1'b1;
                    end
                end
            end
            S_STOP: begin
                if (stop_sample) begin
                    cnt_d = '0;
                    if (rx_sync_q) begin
                        buf_d[ptr_q] = shift_q;
                        ptr_d        = ptr_q + 1'b1;   // 7 wraps to 0
                        done_d       = (ptr_q == 3'd7);
                        state_d      = S_IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        ptr_d   = 3'd0;
                        state_d = S_RECOVER;
                    end
                end
            end
            S_RECOVER: begin
                cnt_d = '0;
                if (rx_sync_q) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, counters, buffer and event-pulse registers.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            bit_idx_q  <= 3'd0;
            shift_q    <= 8'h00;
            ptr_q      <= 3'd0;
            idle_cnt_q <= '0;
            done_q     <= 1'b0;
            ferr_q     <= 1'b0;
            tout_q     <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                buf_q[i] <= 8'h00;
            end
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_idx_q  <= bit_idx_d;
            shift_q    <= shift_d;
            ptr_q      <= ptr_d;
            idle_cnt_q <= idle_cnt_d;
            done_q     <= done_d;
            ferr_q     <= ferr_d;
            tout_q     <= tout_d;
            buf_q      <= buf_d;
        end
    end

    // Registered read port; same-cycle write to the read address returns old data.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            rdata_q <= 8'h00;
        end else begin
            rdata_q <= buf_q[ReadAddr_i];
        end
    end

`ifdef UART_STREAM_RX_CHECK_EN
    logic match_q, match_d;
    logic mism_q, mism_d;
    logic byte_mism;

    function automatic logic [7:0] ref_byte(input logic [2:0] idx);
        case (idx)
            3'd0:    ref_byte = 8'h00;
            3'd1:    ref_byte = 8'h01;
            3'd2:    ref_byte = 8'h03;
            3'd3:    ref_byte = 8'h0F;
            3'd4:    ref_byte = 8'hFF;
            3'd5:    ref_byte = 8'hF0;
            3'd6:    ref_byte = 8'hC0;
            default: ref_byte = 8'h80;
        endcase
    endfunction

    // Running per-frame mismatch tracking; verdict lands with the Done_o pulse.
    always_comb begin
        match_d   = match_q;
        mism_d    = mism_q;
        byte_mism = (shift_q != ref_byte(ptr_q));
        if (stop_sample && rx_sync_q) begin
            if (ptr_q == 3'd0) begin
                mism_d  = byte_mism;
                match_d = 1'b0;
            end else begin
                mism_d = mism_q | byte_mism;
            end
            if (ptr_q == 3'd7) begin
                match_d = !(mism_q | byte_mism);
            end
        end
        if (ferr_d || tout_d) begin
            match_d = 1'b0;
        end
    end

    // Match verdict registers.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            match_q <= 1'b0;
            mism_q  <= 1'b0;
        end else begin
            match_q <= match_d;
            mism_q  <= mism_d;
        end
    end

    assign Match_o = match_q;
`else
    assign Match_o = 1'b0;
`endif

    assign ReadData_o   = rdata_q;
    assign Count_o      = {1'b0, ptr_q};
    assign Busy_o       = (state_q != S_IDLE) || (ptr_q != 3'd0);
    assign Done_o       = done_q;
    assign FrameError_o = ferr_q;
    assign Timeout_o    = tout_q;

endmodule

// File: tb/tb_uart_stream_rx.sv
// Directed bench for uart_stream_rx at 10 clocks per bit. Stored bytes are
// queued as they are sent and popped as the buffer is read back.
module tb_uart_stream_rx;

    localparam int CLOCK_HZ     = 1_152_000;
    localparam int BAUD         = 115200;
    localparam int TIMEOUT_BITS = 20;
    localparam int BIT_CYC      = CLOCK_HZ / BAUD;
    localparam logic [63:0] PAT_FRAME = 64'h80C0F0FF0F030100;   // byte 0 in LSBs
    localparam logic [63:0] BAD_FRAME = 64'h80C0F0FE0F030100;   // byte 4 = FE
`ifdef UART_STREAM_RX_CHECK_EN
    localparam bit CHECK_EN = 1'b1;
`else
    localparam bit CHECK_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx = 1'b1;
    logic [2:0] raddr = 3'd0;
    logic [7:0] rdata;
    logic [3:0] count;
    logic       busy, done, ferr, tout, match;

    int tests_run = 0;
    int tests_failed = 0;
    int done_cnt = 0;
    int ferr_cnt = 0;
    int tout_cnt = 0;
    logic match_at_done = 1'b0;
    logic [7:0] exp_q[$];

    uart_stream_rx #(
        .CLOCK_HZ(CLOCK_HZ),
        .BAUD(BAUD),
        .TIMEOUT_BITS(TIMEOUT_BITS)
    ) dut (
        .Clock(clk),
        .Reset(rst_n),
        .Rx_i(rx),
        .ReadAddr_i(raddr),
        .ReadData_o(rdata),
        .Count_o(count),
        .Busy_o(busy),
        .Done_o(done),
        .FrameError_o(ferr),
        .Timeout_o(tout),
        .Match_o(match)
    );

    // Clock and watchdog
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, tests_run=%0d", tests_run);
        $fatal(1, "watchdog expired");
    end

    // Event monitor: counts pulses and captures Match_o in the Done_o cycle.
    always @(negedge clk) begin
        if (rst_n) begin
            if (done) begin
                done_cnt++;
                match_at_done = match;
            end
            if (ferr) ferr_cnt++;
            if (tout) tout_cnt++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        rx = 1'b0;
        idle(BIT_CYC);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            idle(BIT_CYC);
        end
        rx = stop_bit;
        idle(BIT_CYC);
        if (stop_bit) exp_q.push_back(b);
    endtask

    task automatic send_frame(input logic [63:0] f, output bit m);
        m = (f == PAT_FRAME);
        for (int i = 0; i < 8; i++) begin
            send_byte(f[8*i +: 8], 1'b1);
        end
    endtask

    task automatic read_back(input int n, input string tag);
        logic [7:0] e;
        for (int i = 0; i < n; i++) begin
            raddr = 3'(i);
            @(negedge clk);
            check({tag, "_sb_avail"}, 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check({tag, "_rdata"}, 32'(rdata), 32'(e));
            end
        end
    endtask

    task automatic wait_timeout(output int n, output bit seen);
        n = 0;
        seen = 1'b0;
        while (!seen && n < 400) begin
            @(negedge clk);
            n++;
            seen = tout;
        end
    endtask

    initial begin
        int d0, f0, t0, n;
        bit m, seen;

        // Reset state
        idle(3);
        check("rst_count", 32'(count), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_rdata", 32'(rdata), 32'd0);
        check("rst_match", 32'(match), 32'd0);
        rst_n = 1'b1;
        idle(5);

        // 1: reference frame
        d0 = done_cnt;
        send_frame(PAT_FRAME, m);
        idle(2);
        check("s1_done", 32'(done_cnt), 32'(d0 + 1));
        check("s1_count", 32'(count), 32'd0);
        check("s1_match", 32'(match_at_done), 32'(CHECK_EN & m));
        read_back(8, "s1");

        // 2: short low glitch
        d0 = done_cnt; f0 = ferr_cnt; t0 = tout_cnt;
        rx = 1'b0;
        idle(3);
        rx = 1'b1;
        idle(1);
        check("s2_busy_hi", 32'(busy), 32'd1);
        idle(10);
        check("s2_busy_lo", 32'(busy), 32'd0);
        check("s2_count", 32'(count), 32'd0);
        check("s2_flags", 32'(done_cnt + ferr_cnt + tout_cnt), 32'(d0 + f0 + t0));

        // 3: framing error aborts the frame, held-low line reports once
        d0 = done_cnt; f0 = ferr_cnt;
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        check("s3_count2", 32'(count), 32'd2);
        send_byte(8'h33, 1'b0);
        idle(2);
        check("s3_ferr", 32'(ferr_cnt), 32'(f0 + 1));
        check("s3_count0", 32'(count), 32'd0);
        check("s3_busy_rec", 32'(busy), 32'd1);
        check("s3_match_clr", 32'(match), 32'd0);
        idle(50);
        check("s3_ferr_once", 32'(ferr_cnt), 32'(f0 + 1));
        rx = 1'b1;
        idle(5);
        check("s3_busy_lo", 32'(busy), 32'd0);
        check("s3_no_done", 32'(done_cnt), 32'(d0));
        read_back(2, "s3a");
        send_frame(PAT_FRAME, m);
        idle(2);
        check("s3_done", 32'(done_cnt), 32'(d0 + 1));
        check("s3_match", 32'(match_at_done), 32'(CHECK_EN & m));
        read_back(8, "s3b");

        // 4: idle timeout discards a partial frame, buffer retained
        t0 = tout_cnt;
        send_byte(8'hAA, 1'b1);
        send_byte(8'h55, 1'b1);
        send_byte(8'h5A, 1'b1);
        check("s4_count3", 32'(count), 32'd3);
        wait_timeout(n, seen);
        check("s4_tout_seen", 32'(seen), 32'd1);
        check("s4_tout_window", 32'(n >= 190 && n <= 210), 32'd1);
        idle(1);
        check("s4_count0", 32'(count), 32'd0);
        check("s4_tout_cnt", 32'(tout_cnt), 32'(t0 + 1));
        read_back(3, "s4a");
        send_byte(8'h01, 1'b1);
        send_byte(8'h02, 1'b1);
        send_byte(8'h03, 1'b1);
        idle(19 * BIT_CYC);
        send_byte(8'h04, 1'b1);
        idle(2);
        check("s4_no_tout", 32'(tout_cnt), 32'(t0 + 1));
        check("s4_count4", 32'(count), 32'd4);
        wait_timeout(n, seen);
        check("s4_tout2_seen", 32'(seen), 32'd1);
        idle(1);
        check("s4_count0b", 32'(count), 32'd0);
        read_back(4, "s4b");

        // 5: reset during the data bits of the 5th byte
        d0 = done_cnt;
        for (int i = 0; i < 4; i++) send_byte(8'(8'hA0 + i), 1'b1);
        rx = 1'b0;
        idle(BIT_CYC);
        rx = 1'b1;
        idle(BIT_CYC);
        rx = 1'b0;
        idle(BIT_CYC);
        rst_n = 1'b0;
        rx = 1'b1;
        idle(2);
        check("s5_count", 32'(count), 32'd0);
        check("s5_busy", 32'(busy), 32'd0);
        check("s5_pulses", 32'({done, ferr, tout}), 32'd0);
        check("s5_match", 32'(match), 32'd0);
        check("s5_rdata", 32'(rdata), 32'd0);
        rst_n = 1'b1;
        idle(5);
        exp_q.delete();
        for (int i = 0; i < 8; i++) exp_q.push_back(8'h00);
        read_back(8, "s5a");
        check("s5_no_done", 32'(done_cnt), 32'(d0));
        send_frame(PAT_FRAME, m);
        idle(2);
        check("s5_done", 32'(done_cnt), 32'(d0 + 1));
        read_back(8, "s5b");

        // 6: corrupted frame, then reference frame, then first byte of next
        d0 = done_cnt;
        send_frame(BAD_FRAME, m);
        idle(2);
        check("s6_done_bad", 32'(done_cnt), 32'(d0 + 1));
        check("s6_match_bad", 32'(match_at_done), 32'(CHECK_EN & m));
        read_back(8, "s6a");
        send_frame(PAT_FRAME, m);
        idle(2);
        check("s6_done_good", 32'(done_cnt), 32'(d0 + 2));
        check("s6_match_good", 32'(match_at_done), 32'(CHECK_EN & m));
        read_back(8, "s6b");
        check("s6_match_hold", 32'(match), 32'(CHECK_EN));
        send_byte(8'h00, 1'b1);
        idle(2);
        check("s6_match_clr", 32'(match), 32'd0);
        check("s6_count1", 32'(count), 32'd1);
        read_back(1, "s6c");
        check("sb_empty", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
